// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {IDLE, REQ, RSP, EXEC, HALT, ERR} state_t;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/seq_perf_cnt.sv
// Cycle and retired-instruction counters; compiled only when PERF_CNT_EN is defined.
// Both counters wrap modulo 2^CNT_W.
`ifdef PERF_CNT_EN
module seq_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_en,
  input  logic             ret_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cyc_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (ret_en) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer: REQ -> RSP -> EXEC per instruction, sticky HALT/ERR.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      cmd,
  output logic             pc_wen,
  output logic             rf_wen_gate,
  output logic             halt,
  output logic             fetch_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic [31:0]   cmd_nxt;
  logic          is_ebreak;

  assign is_ebreak = (cmd == INST_EBREAK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      to_cnt <= '0;
      cmd    <= INST_NOP;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      cmd    <= cmd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    cmd_nxt    = cmd;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // Response is not sampled here; memory answers at least one cycle after accept.
        if (imem_req_ready) begin
          state_nxt  = RSP;
          to_cnt_nxt = '0;
        end
      end
      RSP: begin
        if (imem_rsp_valid) begin
          cmd_nxt   = imem_rsp_data;
          state_nxt = EXEC;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = ERR;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      EXEC:    state_nxt = is_ebreak ? HALT : REQ;
      default: state_nxt = state;
    endcase
  end

  // Outputs decode straight from the state register so reset clears them immediately.
  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;
  assign pc_wen         = (state == EXEC) && !is_ebreak;
  assign rf_wen_gate    = (state == EXEC) && !is_ebreak;
  assign halt           = (state == HALT);
  assign fetch_err      = (state == ERR);

`ifdef PERF_CNT_EN
  seq_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .cyc_en      ((state != HALT) && (state != ERR)),
    .ret_en      (state == EXEC),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl (TIMEOUT=8); counter expectations follow PERF_CNT_EN.
module tb_cpu_seq_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] cmd;
  logic        pc_wen, rf_wen_gate, halt, fetch_err;
  logic [63:0] cycle_cnt, instret_cnt;

  int vecs = 0;
  int errs = 0;

  cpu_seq_ctrl #(.XLEN(32), .TIMEOUT(8), .CNT_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .cmd            (cmd),
    .pc_wen         (pc_wen),
    .rf_wen_gate    (rf_wen_gate),
    .halt           (halt),
    .fetch_err      (fetch_err),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
  );

  always #5 clk = ~clk;

  // Holds reset for two cycles and releases it on a falling edge; the next cycle is IDLE.
  task automatic do_reset(input logic [31:0] start_pc);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    pc = start_pc;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid got=%0b exp=0", imem_req_valid); end
    vecs++; if (cmd !== NOP) begin errs++; $display("FAIL rst_cmd got=%h exp=%h", cmd, NOP); end
    vecs++; if ({pc_wen, rf_wen_gate, halt, fetch_err} !== 4'b0) begin errs++; $display("FAIL rst_flags got=%b exp=0000", {pc_wen, rf_wen_gate, halt, fetch_err}); end
    vecs++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin errs++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt); end
  endtask

  task automatic test_basic;
    do_reset(32'h0000_0100);
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL idle_req_valid got=%0b exp=0", imem_req_valid); end
    @(negedge clk); // cycle 1: REQ
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin errs++; $display("FAIL basic_req got=%0b/%h exp=1/00000100", imem_req_valid, imem_addr); end
    imem_req_ready = 1'b1;
    @(negedge clk); // cycle 2: RSP
    vecs++; if (imem_req_valid !== 1'b0 || pc_wen !== 1'b0) begin errs++; $display("FAIL basic_rsp got=%0b/%0b exp=0/0", imem_req_valid, pc_wen); end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    @(negedge clk); // cycle 3: EXEC
    vecs++; if (cmd !== 32'h0050_0093) begin errs++; $display("FAIL basic_cmd got=%h exp=00500093", cmd); end
    vecs++; if (pc_wen !== 1'b1 || rf_wen_gate !== 1'b1) begin errs++; $display("FAIL basic_exec_wen got=%0b/%0b exp=1/1", pc_wen, rf_wen_gate); end
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'hdead_beef; pc = 32'h0000_0104;
    @(negedge clk); // cycle 4: REQ
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h104) begin errs++; $display("FAIL basic_next_req got=%0b/%h exp=1/00000104", imem_req_valid, imem_addr); end
    vecs++; if (pc_wen !== 1'b0 || cmd !== 32'h0050_0093) begin errs++; $display("FAIL basic_after_exec got=%0b/%h exp=0/00500093", pc_wen, cmd); end
  endtask

  // Continues from the REQ state left by test_basic.
  task automatic test_stall;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h104 || pc_wen !== 1'b0) begin errs++; $display("FAIL stall_hold[%0d] got=%0b/%h/%0b exp=1/00000104/0", i, imem_req_valid, imem_addr, pc_wen); end
    end
    imem_req_ready = 1'b1;
    @(negedge clk); // RSP
    imem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vecs++; if (pc_wen !== 1'b0 || cmd !== 32'h0050_0093) begin errs++; $display("FAIL stall_rsp_wait[%0d] got=%0b/%h exp=0/00500093", i, pc_wen, cmd); end
      @(negedge clk);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_8133;
    @(negedge clk); // EXEC
    vecs++; if (cmd !== 32'h0020_8133 || pc_wen !== 1'b1) begin errs++; $display("FAIL stall_exec got=%h/%0b exp=00208133/1", cmd, pc_wen); end
    imem_rsp_valid = 1'b0; pc = 32'h0000_0108;
    @(negedge clk); // REQ
  endtask

  // Continues from REQ; no response ever arrives.
  task automatic test_timeout;
    imem_req_ready = 1'b1;
    @(negedge clk); // RSP cycle 1
    imem_req_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      vecs++; if (fetch_err !== 1'b0 || imem_req_valid !== 1'b0) begin errs++; $display("FAIL timeout_wait[%0d] got=%0b/%0b exp=0/0", i, fetch_err, imem_req_valid); end
      @(negedge clk);
    end
    vecs++; if (fetch_err !== 1'b1) begin errs++; $display("FAIL timeout_err got=%0b exp=1", fetch_err); end
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vecs++; if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0 || pc_wen !== 1'b0) begin errs++; $display("FAIL timeout_sticky[%0d] got=%0b/%0b/%0b exp=1/0/0", i, fetch_err, imem_req_valid, pc_wen); end
    end
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_ebreak;
    do_reset(32'h0000_0200);
    @(negedge clk); // REQ
    imem_req_ready = 1'b1;
    @(negedge clk); // RSP
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = EBREAK;
    @(negedge clk); // EXEC
    imem_rsp_valid = 1'b0;
    vecs++; if (cmd !== EBREAK || pc_wen !== 1'b0 || rf_wen_gate !== 1'b0 || halt !== 1'b0) begin errs++; $display("FAIL ebreak_exec got=%h/%0b/%0b/%0b exp=00100073/0/0/0", cmd, pc_wen, rf_wen_gate, halt); end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vecs++; if (halt !== 1'b1 || imem_req_valid !== 1'b0 || pc_wen !== 1'b0 || rf_wen_gate !== 1'b0) begin errs++; $display("FAIL ebreak_halt[%0d] got=%0b/%0b/%0b/%0b exp=1/0/0/0", i, halt, imem_req_valid, pc_wen, rf_wen_gate); end
    end
    imem_req_ready = 1'b0;
    vecs++; if (instret_cnt !== (PERF ? 64'd1 : 64'd0)) begin errs++; $display("FAIL ebreak_instret got=%0d exp=%0d", instret_cnt, PERF ? 1 : 0); end
    vecs++; if (cycle_cnt !== (PERF ? 64'd4 : 64'd0)) begin errs++; $display("FAIL ebreak_cycles got=%0d exp=%0d", cycle_cnt, PERF ? 4 : 0); end
  endtask

  task automatic test_reset_mid;
    do_reset(32'h0000_0300);
    @(negedge clk); // REQ
    imem_req_ready = 1'b1;
    @(negedge clk); // RSP
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00a0_0513;
    @(negedge clk); // EXEC
    imem_rsp_valid = 1'b0;
    vecs++; if (cmd !== 32'h00a0_0513) begin errs++; $display("FAIL rmid_cmd_pre got=%h exp=00a00513", cmd); end
    @(negedge clk); // REQ
    imem_req_ready = 1'b1;
    @(negedge clk); // RSP
    imem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    vecs++; if (imem_req_valid !== 1'b0 || cmd !== NOP || pc_wen !== 1'b0) begin errs++; $display("FAIL rmid_async got=%0b/%h/%0b exp=0/00000013/0", imem_req_valid, cmd, pc_wen); end
    @(negedge clk);
    rst = 1'b1; // IDLE
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rmid_idle got=%0b exp=0", imem_req_valid); end
    @(negedge clk); // REQ
    vecs++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin errs++; $display("FAIL rmid_req got=%0b/%h exp=1/00000300", imem_req_valid, imem_addr); end
    #2 rst = 1'b0;
    #1;
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rreq_async got=%0b exp=0", imem_req_valid); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back;
    int pulses;
    logic prev_wen;
    pulses = 0;
    prev_wen = 1'b0;
    do_reset(32'h0000_0000);
    @(negedge clk); // REQ
    imem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); // RSP
      imem_rsp_valid = 1'b1; imem_rsp_data = NOP;
      @(negedge clk); // EXEC
      vecs++; if (pc_wen !== 1'b1 || prev_wen !== 1'b0) begin errs++; $display("FAIL b2b_exec[%0d] got=%0b prev=%0b exp=1 prev=0", k, pc_wen, prev_wen); end
      if (pc_wen === 1'b1) pulses++;
      prev_wen = pc_wen;
      imem_rsp_valid = 1'b0;
      @(negedge clk); // REQ
      vecs++; if (pc_wen !== 1'b0 || imem_req_valid !== 1'b1) begin errs++; $display("FAIL b2b_req[%0d] got=%0b/%0b exp=0/1", k, pc_wen, imem_req_valid); end
      prev_wen = pc_wen;
    end
    vecs++; if (pulses != 10) begin errs++; $display("FAIL b2b_pulses got=%0d exp=10", pulses); end
    vecs++; if (instret_cnt !== (PERF ? 64'd10 : 64'd0)) begin errs++; $display("FAIL b2b_instret got=%0d exp=%0d", instret_cnt, PERF ? 10 : 0); end
    vecs++; if (cycle_cnt !== (PERF ? 64'd31 : 64'd0)) begin errs++; $display("FAIL b2b_cycles got=%0d exp=%0d", cycle_cnt, PERF ? 31 : 0); end
    imem_req_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_timeout;
    test_ebreak;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
